// File: rtl/calu_pkg.sv
// Shared types and sizing helpers for the CALU magnitude datapath.
package calu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SQUARE = 2'd1,
    ROOT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int W    = 16;
  localparam int RADW = 2 * W;

  function automatic int radw(input int w);
    return 2 * w;
  endfunction

  // Width of the down-counter that walks the radicand bit pairs.
  function automatic int iter_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/magnitude_seq_if.sv
// Sample-in / result-out handshake bundle for magnitude_seq.
interface magnitude_seq_if #(
  parameter int W = 16
);
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] Real;
  logic signed [W-1:0] Imaginary;
  logic                sq_mode;
  logic                out_valid;
  logic                out_ready;
  logic [2*W-1:0]      Mag;

  modport slave (
    input  in_valid, Real, Imaginary, sq_mode, out_ready,
    output in_ready, out_valid, Mag
  );

  modport master (
    output in_valid, Real, Imaginary, sq_mode, out_ready,
    input  in_ready, out_valid, Mag
  );
endinterface

// File: rtl/isqrt_step.sv
// One restoring square-root iteration: shift in two radicand bits, try (root<<2)|1.
module isqrt_step #(
  parameter int W = 16
) (
  input  logic [W+1:0] rem,
  input  logic [W-1:0] root,
  input  logic [1:0]   pair,
  output logic [W+1:0] rem_nxt,
  output logic [W-1:0] root_nxt
);
  logic [W+1:0] rem_sh;
  logic [W+1:0] trial;
  logic         ge;

  // rem never exceeds 2*root, so its top two bits are zero before the shift.
  assign rem_sh   = {rem[W-1:0], pair};
  assign trial    = {root, 2'b01};
  assign ge       = (rem_sh >= trial);
  assign rem_nxt  = ge ? (rem_sh - trial) : rem_sh;
  assign root_nxt = {root[W-2:0], ge};
endmodule

// File: rtl/magnitude_seq.sv
// Handshaked complex magnitude: exact Real^2+Imaginary^2, optionally reduced to floor(sqrt)
// by a W-cycle digit-by-digit root. Not pipelined; one sample in flight at a time.
module magnitude_seq
  import calu_pkg::*;
#(
  parameter int W          = 16,
  parameter bit SQ_ONLY_EN = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  magnitude_seq_if.slave bus
);
  localparam int RW = radw(W);
  localparam int IW = iter_w(W);

  state_t              state;
  logic signed [W-1:0] re_q;
  logic signed [W-1:0] im_q;
  logic                sq_q;
  logic [RW-1:0]       radicand;
  logic [W+1:0]        rem;
  logic [W-1:0]        root;
  logic [IW-1:0]       iter;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [RW-1:0]       mag_q;

  logic signed [RW-1:0] re_sq;
  logic signed [RW-1:0] im_sq;
  logic [RW-1:0]        sum_sq;
  logic [1:0]           pair;
  logic [W+1:0]         rem_nxt;
  logic [W-1:0]         root_nxt;

  // Each square is at most 2^(2W-2), so the unsigned sum fits in 2W bits.
  always_comb begin
    re_sq  = RW'(re_q) * RW'(re_q);
    im_sq  = RW'(im_q) * RW'(im_q);
    sum_sq = $unsigned(re_sq) + $unsigned(im_sq);
  end

  assign pair = radicand[{iter, 1'b0} +: 2];

  isqrt_step #(.W(W)) u_step (
    .rem      (rem),
    .root     (root),
    .pair     (pair),
    .rem_nxt  (rem_nxt),
    .root_nxt (root_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      re_q        <= '0;
      im_q        <= '0;
      sq_q        <= 1'b0;
      radicand    <= '0;
      rem         <= '0;
      root        <= '0;
      iter        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      mag_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            re_q       <= bus.Real;
            im_q       <= bus.Imaginary;
            sq_q       <= SQ_ONLY_EN ? bus.sq_mode : 1'b0;
            in_ready_q <= 1'b0;
            state      <= SQUARE;
          end
        end
        SQUARE: begin
          radicand <= sum_sq;
          if (sq_q) begin
            mag_q       <= sum_sq;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            rem   <= '0;
            root  <= '0;
            iter  <= IW'(W - 1);
            state <= ROOT;
          end
        end
        ROOT: begin
          rem  <= rem_nxt;
          root <= root_nxt;
          if (iter == '0) begin
            mag_q       <= {{W{1'b0}}, root_nxt};
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            iter <= iter - 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.Mag       = mag_q;
endmodule

// File: tb/tb_magnitude_seq.sv
// Bench for magnitude_seq: directed corner cases plus randomized samples against a sqrt model.
module tb_magnitude_seq;
  localparam int W = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  magnitude_seq_if #(.W(W)) bus ();

  magnitude_seq #(.W(W), .SQ_ONLY_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference: exact sum of squares, then integer square root by correction around a real estimate.
  function automatic longint ref_mag(input int a, input int b, input bit sq);
    longint s;
    longint r;
    s = longint'(a) * a + longint'(b) * b;
    if (sq) return s;
    r = longint'($floor($sqrt(real'(s))));
    while ((r + 1) * (r + 1) <= s) r++;
    while (r > 0 && r * r > s) r--;
    return r;
  endfunction

  task automatic accept(input int a, input int b, input bit sq);
    int t;
    t = 0;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t == 200) check_eq("in_ready_timeout", 64'd0, 64'd1);
    @(negedge clk);
    bus.Real      = W'(a);
    bus.Imaginary = W'(b);
    bus.sq_mode   = sq;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.Real      = W'($urandom);
    bus.Imaginary = W'($urandom);
    bus.sq_mode   = $urandom_range(0, 1);
  endtask

  // Returns the number of edges from the accepting edge to the first edge that sees out_valid=1.
  task automatic wait_result(output int lat);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.out_valid && n < 200);
    if (n == 200) check_eq("out_valid_timeout", 64'd0, 64'd1);
    lat = n + 1;
  endtask

  task automatic release_result(input int gap);
    repeat (gap) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_one(input string tag, input int a, input int b, input bit sq);
    int lat;
    accept(a, b, sq);
    wait_result(lat);
    check_eq({tag, "_lat"}, 64'(lat), sq ? 64'd2 : 64'(W + 2));
    check_eq({tag, "_mag"}, 64'(bus.Mag), 64'(ref_mag(a, b, sq)));
    release_result(0);
    check_eq({tag, "_drop"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    longint exp_q[$];
    longint exp_v;
    int     lat;
    n_checks = 0;
    n_errors = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.Real      = '0;
    bus.Imaginary = '0;
    bus.sq_mode   = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_mag", 64'(bus.Mag), 64'd0);
    rst_n = 1'b1;

    run_one("t_3_4", 3, 4, 1'b0);
    check_eq("t_3_4_abs", 64'(bus.Mag), 64'd5);
    run_one("t_min_root", -32768, -32768, 1'b0);
    check_eq("t_min_root_abs", 64'(bus.Mag), 64'd46340);
    run_one("t_min_sq", -32768, -32768, 1'b1);
    check_eq("t_min_sq_abs", 64'(bus.Mag), 64'h8000_0000);
    run_one("t_zero", 0, 0, 1'b0);
    run_one("t_neg1", -1, 0, 1'b0);
    run_one("t_max", 32767, 0, 1'b0);
    check_eq("t_max_abs", 64'(bus.Mag), 64'd32767);

    // Backpressure: result must sit untouched while out_ready stays low.
    accept(6, 8, 1'b0);
    wait_result(lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("bp_mag", 64'(bus.Mag), 64'd10);
      check_eq("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check_eq("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check_eq("bp_in_ready_after", 64'(bus.in_ready), 64'd1);
    check_eq("bp_out_valid_after", 64'(bus.out_valid), 64'd0);
    check_eq("bp_mag_hold", 64'(bus.Mag), 64'd10);

    // Reset while the root is half computed (iteration 8).
    accept(7, 24, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("mid_rst_mag", 64'(bus.Mag), 64'd0);
    repeat (20) @(posedge clk);
    #1;
    check_eq("mid_rst_no_result", 64'(bus.out_valid), 64'd0);
    run_one("t_5_12", 5, 12, 1'b0);
    check_eq("t_5_12_abs", 64'(bus.Mag), 64'd13);

    // Randomized regression with random output stalls; results must come back in order.
    for (int i = 0; i < 1500; i++) begin
      logic signed [W-1:0] ra;
      logic signed [W-1:0] rb;
      bit                  rs;
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom_range(0, 1));
      accept(int'(ra), int'(rb), rs);
      exp_q.push_back(ref_mag(int'(ra), int'(rb), rs));
      wait_result(lat);
      check_eq("rnd_lat", 64'(lat), rs ? 64'd2 : 64'(W + 2));
      exp_v = exp_q.pop_front();
      check_eq("rnd_mag", 64'(bus.Mag), 64'(exp_v));
      release_result($urandom_range(0, 3));
      check_eq("rnd_drop", 64'(bus.out_valid), 64'd0);
    end
    check_eq("rnd_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
